// File: rtl/median_pkg.sv
// Shared types and helpers for the streaming sliding-window median filter.
`define MEDIAN_PARAM_CHECK(win, nsamp) \
  if ((win) < 3 || (win) > 9 || ((win) % 2) == 0 || (nsamp) < (win)) begin : g_bad_params \
    $error("median filter: WINDOW must be odd in 3..9 and NUM_SAMPLES >= WINDOW"); \
  end

package median_pkg;

  typedef enum logic [1:0] {
    StFill,
    StRun,
    StFlush
  } state_e;

  // Rank of the median inside a window of the given (odd) length.
  function automatic int unsigned median_mid(input int unsigned window);
    return (window - 1) / 2;
  endfunction

endpackage

// File: rtl/median_select.sv
// Combinational median of a flattened window using rank counting.
// Ties are broken by index so exactly one element owns the middle rank.
module median_select
  import median_pkg::*;
#(
  parameter int unsigned WIDTH  = 32,
  parameter int unsigned WINDOW = 3,
  parameter bit          SIGNED = 1'b0
) (
  input  logic [WINDOW*WIDTH-1:0] window,
  output logic [WIDTH-1:0]        median
);

  localparam int unsigned MID   = median_mid(WINDOW);
  localparam int unsigned RankW = $clog2(WINDOW);

  logic [WIDTH-1:0] x    [WINDOW];
  logic [RankW-1:0] rank [WINDOW];

  for (genvar i = 0; i < WINDOW; i++) begin : g_unpack
    assign x[i] = window[i*WIDTH +: WIDTH];
  end

  function automatic logic less(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
    if (SIGNED) return $signed(a) < $signed(b);
    return a < b;
  endfunction

  always_comb begin
    for (int i = 0; i < WINDOW; i++) begin
      rank[i] = '0;
      for (int j = 0; j < WINDOW; j++) begin
        if (less(x[j], x[i]) || (j < i && x[j] == x[i])) begin
          rank[i] = rank[i] + RankW'(1);
        end
      end
    end
  end

  always_comb begin
    median = '0;
    for (int i = 0; i < WINDOW; i++) begin
      if (rank[i] == RankW'(MID)) median = x[i];
    end
  end

endmodule

// File: rtl/median_stream_filter.sv
// Streaming sliding-window median filter with ready/valid on both sides.
// Emits NUM_SAMPLES-WINDOW+1 medians per frame, then pulses frame_done and re-arms.
module median_stream_filter
  import median_pkg::*;
#(
  parameter int unsigned WIDTH       = 32,
  parameter int unsigned WINDOW      = 3,
  parameter int unsigned NUM_SAMPLES = 8533,
  parameter bit          SIGNED      = 1'b0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             frame_done
);

  `MEDIAN_PARAM_CHECK(WINDOW, NUM_SAMPLES)

  localparam int unsigned     CntW      = $clog2(NUM_SAMPLES + 1);
  localparam logic [CntW-1:0] FillLast  = CntW'(WINDOW - 1);
  localparam logic [CntW-1:0] FrameLast = CntW'(NUM_SAMPLES);

  state_e                  state_q, state_d;
  logic [CntW-1:0]         cnt_q, cnt_d, cnt_inc;
  logic [WIDTH-1:0]        win_q     [WINDOW];
  logic [WIDTH-1:0]        win_d     [WINDOW];
  logic [WIDTH-1:0]        win_shift [WINDOW];
  logic [WINDOW*WIDTH-1:0] win_flat;
  logic                    out_valid_q, out_valid_d;
  logic [WIDTH-1:0]        out_data_q, out_data_d;
  logic [WIDTH-1:0]        median;
  logic                    accept, out_fire;

  // Candidate next window: newest sample at index 0, oldest falls off the end.
  for (genvar i = 0; i < WINDOW; i++) begin : g_win
    if (i == 0) begin : g_head
      assign win_shift[i] = in_data;
    end else begin : g_tail
      assign win_shift[i] = win_q[i-1];
    end
    assign win_flat[i*WIDTH +: WIDTH] = win_shift[i];
  end

  median_select #(
    .WIDTH (WIDTH),
    .WINDOW(WINDOW),
    .SIGNED(SIGNED)
  ) u_select (
    .window(win_flat),
    .median(median)
  );

  assign accept   = in_valid && in_ready;
  assign out_fire = out_valid && out_ready;
  assign cnt_inc  = cnt_q + CntW'(1);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StFill;
      cnt_q       <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      for (int i = 0; i < WINDOW; i++) win_q[i] <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      win_q       <= win_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    win_d       = win_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    if (out_fire) out_valid_d = 1'b0;
    if (accept) begin
      win_d = win_shift;
      cnt_d = cnt_inc;
    end
    case (state_q)
      StFill: begin
        if (accept && cnt_inc == FillLast) state_d = StRun;
      end
      StRun: begin
        if (accept) begin
          out_valid_d = 1'b1;
          out_data_d  = median;
          if (cnt_inc == FrameLast) state_d = StFlush;
        end
      end
      StFlush: begin
        if (out_fire) begin
          state_d = StFill;
          cnt_d   = '0;
          for (int i = 0; i < WINDOW; i++) win_d[i] = '0;
        end
      end
      default: state_d = StFill;
    endcase
  end

  // Outputs are forced quiet while reset is asserted, not just after it.
  always_comb begin
    in_ready   = !rst && (state_q != StFlush) && (!out_valid_q || out_ready);
    out_valid  = out_valid_q && !rst;
    out_data   = rst ? '0 : out_data_q;
    frame_done = out_valid && out_ready && (state_q == StFlush);
  end

endmodule

// File: tb/tb_median_stream_filter.sv
// Self-checking bench for median_stream_filter: directed scenarios plus randomized
// streams checked against a sort-based reference model.
module tb_median_stream_filter;

  typedef logic [31:0] q_t[$];

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  // DUT A: 32-bit, window 3, 6 samples, unsigned
  logic        a_in_valid, a_in_ready, a_out_valid, a_out_ready, a_frame_done;
  logic [31:0] a_in_data, a_out_data;
  // DUT B: 32-bit, window 5, 7 samples, unsigned
  logic        b_in_valid, b_in_ready, b_out_valid, b_out_ready, b_frame_done;
  logic [31:0] b_in_data, b_out_data;
  // DUTs S/U: 8-bit, window 3, 3 samples, signed / unsigned, shared inputs
  logic        c_in_valid, c_out_ready;
  logic [7:0]  c_in_data;
  logic        s_in_ready, s_out_valid, s_frame_done;
  logic        u_in_ready, u_out_valid, u_frame_done;
  logic [7:0]  s_out_data, u_out_data;

  median_stream_filter #(.WIDTH(32), .WINDOW(3), .NUM_SAMPLES(6), .SIGNED(1'b0)) dut_a (
    .clk(clk), .rst(rst), .in_valid(a_in_valid), .in_ready(a_in_ready), .in_data(a_in_data),
    .out_valid(a_out_valid), .out_ready(a_out_ready), .out_data(a_out_data),
    .frame_done(a_frame_done)
  );

  median_stream_filter #(.WIDTH(32), .WINDOW(5), .NUM_SAMPLES(7), .SIGNED(1'b0)) dut_b (
    .clk(clk), .rst(rst), .in_valid(b_in_valid), .in_ready(b_in_ready), .in_data(b_in_data),
    .out_valid(b_out_valid), .out_ready(b_out_ready), .out_data(b_out_data),
    .frame_done(b_frame_done)
  );

  median_stream_filter #(.WIDTH(8), .WINDOW(3), .NUM_SAMPLES(3), .SIGNED(1'b1)) dut_s (
    .clk(clk), .rst(rst), .in_valid(c_in_valid), .in_ready(s_in_ready), .in_data(c_in_data),
    .out_valid(s_out_valid), .out_ready(c_out_ready), .out_data(s_out_data),
    .frame_done(s_frame_done)
  );

  median_stream_filter #(.WIDTH(8), .WINDOW(3), .NUM_SAMPLES(3), .SIGNED(1'b0)) dut_u (
    .clk(clk), .rst(rst), .in_valid(c_in_valid), .in_ready(u_in_ready), .in_data(c_in_data),
    .out_valid(u_out_valid), .out_ready(c_out_ready), .out_data(u_out_data),
    .frame_done(u_frame_done)
  );

  // Output monitors: a transfer seen at the negedge completes on the next posedge.
  q_t a_got, b_got;
  int a_fd_pos[$];
  int b_fd_pos[$];

  always @(negedge clk) begin
    if (!rst) begin
      if (a_out_valid && a_out_ready) a_got.push_back(a_out_data);
      if (a_frame_done) a_fd_pos.push_back(a_got.size());
      if (b_out_valid && b_out_ready) b_got.push_back(b_out_data);
      if (b_frame_done) b_fd_pos.push_back(b_got.size());
    end
  end

  // Reference model: sort each full window and take its middle element.
  function automatic longint sort_key(input logic [31:0] v, input int width, input bit sgn);
    longint k;
    k = longint'(v);
    if (sgn && v[width-1]) k = k - (longint'(1) << width);
    return k;
  endfunction

  function automatic q_t ref_medians(input q_t s, input int w, input int n, input bit sgn,
                                     input int width);
    q_t          res;
    q_t          win;
    logic [31:0] tmp;
    for (int f = 0; f + n <= s.size(); f += n) begin
      for (int k = w - 1; k < n; k++) begin
        win = {};
        for (int j = k - w + 1; j <= k; j++) win.push_back(s[f+j]);
        for (int a = 1; a < w; a++) begin
          for (int b = a; b > 0; b--) begin
            if (sort_key(win[b-1], width, sgn) > sort_key(win[b], width, sgn)) begin
              tmp = win[b]; win[b] = win[b-1]; win[b-1] = tmp;
            end
          end
        end
        res.push_back(win[w/2]);
      end
    end
    return res;
  endfunction

  bit a_in_done;

  // mode 0: back-to-back, 1: in_valid every other cycle, 2: random bubbles
  task automatic drive_a(input q_t s, input int mode, input int stall_pct);
    int i;
    int cyc;
    bit acc;
    a_in_done = 1'b0;
    fork
      begin
        i = 0;
        cyc = 0;
        while (i < s.size() && cyc < 2000) begin
          if (mode == 0) a_in_valid = 1'b1;
          else if (mode == 1) a_in_valid = (cyc % 2 == 0);
          else a_in_valid = ($urandom_range(99) >= 40);
          a_in_data = s[i];
          @(negedge clk);
          acc = a_in_valid && a_in_ready;
          @(posedge clk); #1;
          if (acc) i++;
          cyc++;
        end
        a_in_valid = 1'b0;
        checks++;
        if (i != s.size()) begin
          failures++;
          $display("FAIL drive_a_timeout accepted=%0d required=%0d", i, s.size());
        end
        a_in_done = 1'b1;
      end
      begin
        while (!a_in_done) begin
          a_out_ready = ($urandom_range(99) >= stall_pct);
          @(posedge clk); #1;
        end
      end
    join
    a_out_ready = 1'b1;
    repeat (4) @(posedge clk);
    #1;
  endtask

  task automatic drive_b(input q_t s);
    int i = 0;
    int cyc = 0;
    bit acc;
    while (i < s.size() && cyc < 2000) begin
      b_in_valid  = 1'b1;
      b_in_data   = s[i];
      b_out_ready = ($urandom_range(3) != 0);
      @(negedge clk);
      acc = b_in_ready;
      @(posedge clk); #1;
      if (acc) i++;
      cyc++;
    end
    b_in_valid  = 1'b0;
    b_out_ready = 1'b1;
    checks++;
    if (i != s.size()) begin
      failures++;
      $display("FAIL drive_b_timeout accepted=%0d required=%0d", i, s.size());
    end
    repeat (4) @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    a_in_valid = 1'b1; a_in_data = 32'd77; a_out_ready = 1'b1;
    b_in_valid = 1'b0; b_in_data = '0;     b_out_ready = 1'b1;
    c_in_valid = 1'b0; c_in_data = '0;     c_out_ready = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    checks++;
    if (a_in_ready !== 1'b0 || a_out_valid !== 1'b0 || a_out_data !== 32'd0 ||
        a_frame_done !== 1'b0) begin
      failures++;
      $display("FAIL reset_outputs got rdy=%b vld=%b data=%0d fd=%b want 0/0/0/0",
               a_in_ready, a_out_valid, a_out_data, a_frame_done);
    end
    @(posedge clk); #1;
    rst = 1'b0;
    a_in_valid = 1'b0;
    @(negedge clk);
    checks++;
    if (a_in_ready !== 1'b1 || a_out_valid !== 1'b0 || b_in_ready !== 1'b1 ||
        s_in_ready !== 1'b1) begin
      failures++;
      $display("FAIL reset_release got a_rdy=%b a_vld=%b b_rdy=%b s_rdy=%b want 1/0/1/1",
               a_in_ready, a_out_valid, b_in_ready, s_in_ready);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_basic();
    q_t s   = '{32'd5, 32'd1, 32'd9, 32'd3, 32'd3, 32'd7};
    q_t exp = '{32'd5, 32'd3, 32'd3, 32'd3};
    a_out_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      a_in_valid = 1'b1;
      a_in_data  = s[i];
      @(negedge clk);
      checks++;
      if (a_in_ready !== 1'b1 || a_out_valid !== (i >= 3) || a_frame_done !== 1'b0) begin
        failures++;
        $display("FAIL basic_ctrl[%0d] got rdy=%b vld=%b fd=%b want 1/%b/0",
                 i, a_in_ready, a_out_valid, a_frame_done, (i >= 3));
      end
      if (i >= 3) begin
        checks++;
        if (a_out_data !== exp[i-3]) begin
          failures++;
          $display("FAIL basic_out[%0d] got=%0d want=%0d", i - 3, a_out_data, exp[i-3]);
        end
      end
      @(posedge clk); #1;
    end
    a_in_valid = 1'b0;
    @(negedge clk);
    checks++;
    if (a_out_valid !== 1'b1 || a_out_data !== exp[3] || a_frame_done !== 1'b1 ||
        a_in_ready !== 1'b0) begin
      failures++;
      $display("FAIL basic_last got vld=%b data=%0d fd=%b rdy=%b want 1/%0d/1/0",
               a_out_valid, a_out_data, a_frame_done, a_in_ready, exp[3]);
    end
    @(posedge clk); #1;
    @(negedge clk);
    checks++;
    if (a_out_valid !== 1'b0 || a_frame_done !== 1'b0 || a_in_ready !== 1'b1) begin
      failures++;
      $display("FAIL basic_rearm got vld=%b fd=%b rdy=%b want 0/0/1",
               a_out_valid, a_frame_done, a_in_ready);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_backpressure();
    q_t s   = '{32'd5, 32'd1, 32'd9, 32'd3, 32'd3, 32'd7};
    q_t exp = '{32'd5, 32'd3, 32'd3, 32'd3};
    int i = 0;
    int stall = -1;
    int cyc = 0;
    bit acc;
    a_got.delete();
    a_fd_pos.delete();
    while ((i < 6 || a_out_valid) && cyc < 100) begin
      if (a_out_valid && stall < 0) stall = 4;
      a_out_ready = !(stall > 0);
      a_in_valid  = (i < 6);
      if (i < 6) a_in_data = s[i];
      @(negedge clk);
      if (stall > 0) begin
        checks++;
        if (a_out_data !== 32'd5 || a_in_ready !== 1'b0 || a_out_valid !== 1'b1) begin
          failures++;
          $display("FAIL bp_hold got data=%0d rdy=%b vld=%b want 5/0/1",
                   a_out_data, a_in_ready, a_out_valid);
        end
        stall--;
      end
      acc = a_in_valid && a_in_ready;
      @(posedge clk); #1;
      if (acc) i++;
      cyc++;
    end
    a_in_valid  = 1'b0;
    a_out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (a_got.size() != exp.size()) begin
      failures++;
      $display("FAIL bp_count got=%0d want=%0d", a_got.size(), exp.size());
    end
    for (int k = 0; k < exp.size() && k < a_got.size(); k++) begin
      checks++;
      if (a_got[k] !== exp[k]) begin
        failures++;
        $display("FAIL bp_out[%0d] got=%0d want=%0d", k, a_got[k], exp[k]);
      end
    end
    checks++;
    if (a_fd_pos.size() != 1 || (a_fd_pos.size() == 1 && a_fd_pos[0] != 4)) begin
      failures++;
      $display("FAIL bp_frame_done pulses=%0d want one pulse with output 4", a_fd_pos.size());
    end
  endtask

  task automatic test_signed();
    logic [7:0] smp[3];
    q_t         qs;
    q_t         exp_s, exp_u;
    int         cyc;
    bit         acc;
    c_out_ready = 1'b1;
    for (int f = 0; f < 12; f++) begin
      if (f == 0) begin
        smp[0] = 8'hFF; smp[1] = 8'h02; smp[2] = 8'h00;
      end else begin
        for (int j = 0; j < 3; j++) smp[j] = 8'($urandom);
      end
      qs = {};
      for (int j = 0; j < 3; j++) qs.push_back({24'd0, smp[j]});
      exp_s = ref_medians(qs, 3, 3, 1'b1, 8);
      exp_u = ref_medians(qs, 3, 3, 1'b0, 8);
      for (int j = 0; j < 3; j++) begin
        c_in_valid = 1'b1;
        c_in_data  = smp[j];
        cyc = 0;
        acc = 1'b0;
        while (!acc && cyc < 20) begin
          @(negedge clk);
          acc = s_in_ready && u_in_ready;
          @(posedge clk); #1;
          cyc++;
        end
        checks++;
        if (!acc) begin
          failures++;
          $display("FAIL signed_accept_timeout frame=%0d sample=%0d got=0 want=1", f, j);
        end
      end
      c_in_valid = 1'b0;
      @(negedge clk);
      checks++;
      if (s_out_valid !== 1'b1 || s_out_data !== exp_s[0][7:0] || s_frame_done !== 1'b1) begin
        failures++;
        $display("FAIL signed_median frame=%0d got vld=%b data=%h fd=%b want 1/%h/1",
                 f, s_out_valid, s_out_data, s_frame_done, exp_s[0][7:0]);
      end
      checks++;
      if (u_out_valid !== 1'b1 || u_out_data !== exp_u[0][7:0] || u_frame_done !== 1'b1) begin
        failures++;
        $display("FAIL unsigned_median frame=%0d got vld=%b data=%h fd=%b want 1/%h/1",
                 f, u_out_valid, u_out_data, u_frame_done, exp_u[0][7:0]);
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_window5_frames();
    q_t s   = '{32'd4, 32'd4, 32'd1, 32'd4, 32'd9, 32'd0, 32'd2,
                32'd1, 32'd2, 32'd3, 32'd4, 32'd5, 32'd6, 32'd7};
    q_t exp = '{32'd4, 32'd4, 32'd2, 32'd3, 32'd4, 32'd5};
    for (int r = 0; r < 2; r++) begin
      if (r == 1) begin
        s = {};
        for (int k = 0; k < 21; k++) s.push_back(32'($urandom_range(5)));
        exp = ref_medians(s, 5, 7, 1'b0, 32);
      end
      b_got.delete();
      b_fd_pos.delete();
      drive_b(s);
      checks++;
      if (b_got.size() != exp.size()) begin
        failures++;
        $display("FAIL w5_count run=%0d got=%0d want=%0d", r, b_got.size(), exp.size());
      end
      for (int k = 0; k < exp.size() && k < b_got.size(); k++) begin
        checks++;
        if (b_got[k] !== exp[k]) begin
          failures++;
          $display("FAIL w5_out run=%0d [%0d] got=%0d want=%0d", r, k, b_got[k], exp[k]);
        end
      end
      checks++;
      if (b_fd_pos.size() != exp.size() / 3) begin
        failures++;
        $display("FAIL w5_frame_done_count run=%0d got=%0d want=%0d",
                 r, b_fd_pos.size(), exp.size() / 3);
      end
      for (int k = 0; k < b_fd_pos.size(); k++) begin
        checks++;
        if (b_fd_pos[k] != 3 * (k + 1)) begin
          failures++;
          $display("FAIL w5_frame_done_pos run=%0d [%0d] got=%0d want=%0d",
                   r, k, b_fd_pos[k], 3 * (k + 1));
        end
      end
    end
  endtask

  task automatic test_reset_mid();
    q_t s   = '{32'd5, 32'd1, 32'd9, 32'd3, 32'd3, 32'd7};
    q_t exp = '{32'd5, 32'd3, 32'd3, 32'd3};
    a_out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      a_in_valid = 1'b1;
      a_in_data  = s[i];
      @(negedge clk);
      @(posedge clk); #1;
    end
    checks++;
    if (a_out_valid !== 1'b1) begin
      failures++;
      $display("FAIL midrst_pre got vld=%b want 1", a_out_valid);
    end
    rst = 1'b1;
    a_in_data = 32'd99;
    @(negedge clk);
    checks++;
    if (a_in_ready !== 1'b0 || a_out_valid !== 1'b0 || a_frame_done !== 1'b0) begin
      failures++;
      $display("FAIL midrst_during got rdy=%b vld=%b fd=%b want 0/0/0",
               a_in_ready, a_out_valid, a_frame_done);
    end
    @(posedge clk); #1;
    rst = 1'b0;
    a_in_valid = 1'b0;
    @(negedge clk);
    checks++;
    if (a_out_valid !== 1'b0 || a_frame_done !== 1'b0 || a_in_ready !== 1'b1) begin
      failures++;
      $display("FAIL midrst_after got vld=%b fd=%b rdy=%b want 0/0/1",
               a_out_valid, a_frame_done, a_in_ready);
    end
    @(posedge clk); #1;
    a_got.delete();
    a_fd_pos.delete();
    drive_a(s, 0, 0);
    checks++;
    if (a_got.size() != exp.size()) begin
      failures++;
      $display("FAIL midrst_count got=%0d want=%0d", a_got.size(), exp.size());
    end
    for (int k = 0; k < exp.size() && k < a_got.size(); k++) begin
      checks++;
      if (a_got[k] !== exp[k]) begin
        failures++;
        $display("FAIL midrst_out[%0d] got=%0d want=%0d", k, a_got[k], exp[k]);
      end
    end
    checks++;
    if (a_fd_pos.size() != 1 || (a_fd_pos.size() == 1 && a_fd_pos[0] != 4)) begin
      failures++;
      $display("FAIL midrst_frame_done pulses=%0d want one pulse with output 4",
               a_fd_pos.size());
    end
  endtask

  // r=0: in_valid toggles; r>0: random data, bubbles and backpressure over 3 frames
  task automatic test_bubbles_random();
    q_t s;
    q_t exp;
    for (int r = 0; r < 4; r++) begin
      if (r == 0) begin
        s = '{32'd5, 32'd1, 32'd9, 32'd3, 32'd3, 32'd7};
      end else begin
        s = {};
        for (int k = 0; k < 18; k++) s.push_back((r == 1) ? $urandom : 32'($urandom_range(3)));
      end
      exp = ref_medians(s, 3, 6, 1'b0, 32);
      a_got.delete();
      a_fd_pos.delete();
      drive_a(s, (r == 0) ? 1 : 2, (r == 0) ? 0 : 30);
      checks++;
      if (a_got.size() != exp.size()) begin
        failures++;
        $display("FAIL rnd_count run=%0d got=%0d want=%0d", r, a_got.size(), exp.size());
      end
      for (int k = 0; k < exp.size() && k < a_got.size(); k++) begin
        checks++;
        if (a_got[k] !== exp[k]) begin
          failures++;
          $display("FAIL rnd_out run=%0d [%0d] got=%0d want=%0d", r, k, a_got[k], exp[k]);
        end
      end
      checks++;
      if (a_fd_pos.size() != exp.size() / 4) begin
        failures++;
        $display("FAIL rnd_frame_done_count run=%0d got=%0d want=%0d",
                 r, a_fd_pos.size(), exp.size() / 4);
      end
      for (int k = 0; k < a_fd_pos.size(); k++) begin
        checks++;
        if (a_fd_pos[k] != 4 * (k + 1)) begin
          failures++;
          $display("FAIL rnd_frame_done_pos run=%0d [%0d] got=%0d want=%0d",
                   r, k, a_fd_pos[k], 4 * (k + 1));
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_backpressure();
    test_signed();
    test_window5_frames();
    test_reset_mid();
    test_bubbles_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog simulation did not finish in time");
    $fatal(1);
  end

endmodule
